// File: rtl/csr_writeback_stage_if.sv
// Bundle of retiring-instruction inputs, CSR read-back data and writeback/redirect outputs.
// master = upstream/CSR side, slave = the writeback stage.
interface csr_writeback_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [2:0]  in_csr_cmd;
   logic [1:0]  in_wb_sel;
   logic        in_rf_wen;
   logic [4:0]  in_rd;
   logic [31:0] in_alu_out;
   logic [31:0] in_mem_rdata;
   logic        in_br_taken;
   logic [31:0] in_br_target;
   logic [31:0] csr_rdata;
   logic [31:0] trap_vector;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        wb_branch_hazard;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [63:0] retire_count;

   modport master (
      output in_valid, in_pc, in_csr_cmd, in_wb_sel, in_rf_wen, in_rd,
             in_alu_out, in_mem_rdata, in_br_taken, in_br_target,
             csr_rdata, trap_vector,
      input  in_ready, rf_wen, rf_waddr, rf_wdata, wb_branch_hazard,
             redirect_valid, redirect_pc, retire_count
   );

   modport slave (
      input  in_valid, in_pc, in_csr_cmd, in_wb_sel, in_rf_wen, in_rd,
             in_alu_out, in_mem_rdata, in_br_taken, in_br_target,
             csr_rdata, trap_vector,
      output in_ready, rf_wen, rf_waddr, rf_wdata, wb_branch_hazard,
             redirect_valid, redirect_pc, retire_count
   );
endinterface

// File: rtl/csr_writeback_stage.sv
// Writeback stage after the CSR stage: waits out CSR read latency, writes rd,
// and resolves branch/ECALL redirects with a fixed-length squash window.
module csr_writeback_stage #(
   parameter int CSR_LATENCY  = 1,
   parameter int FLUSH_CYCLES = 2
) (
   input logic                  clk,
   input logic                  rst,
   csr_writeback_stage_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, CSR_WAIT = 2'd1, FLUSH = 2'd2} state_t;

   localparam logic [2:0] CMD_E = 3'd4;

   state_t      state, state_next;
   logic [1:0]  wait_cnt;
   logic [3:0]  flush_cnt;
   logic [4:0]  held_rd;
   logic        held_wen;
   logic        held_ecall;
   logic        accept, is_csr, wait_done, flush_done;

   logic        rf_wen_q, rf_wen_d;
   logic [4:0]  rf_waddr_q, rf_waddr_d;
   logic [31:0] rf_wdata_q, rf_wdata_d;
   logic        redirect_q, redirect_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        hazard_q;
   logic        retire_d;
   logic [63:0] retire_q;
   logic [31:0] sel_data;

   assign bus.in_ready = (state != CSR_WAIT);
   assign accept       = bus.in_valid && bus.in_ready;
   assign is_csr       = (bus.in_csr_cmd >= 3'd1) && (bus.in_csr_cmd <= CMD_E);
   assign wait_done    = (state == CSR_WAIT) && (wait_cnt == 2'd0);
   assign flush_done   = (state == FLUSH) && (flush_cnt == 4'd0);

   // State register plus the wait/flush counters and the held CSR instruction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= 2'd0;
         flush_cnt  <= 4'd0;
         held_rd    <= 5'd0;
         held_wen   <= 1'b0;
         held_ecall <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && accept && is_csr) begin
            wait_cnt   <= 2'(CSR_LATENCY - 1);
            held_rd    <= bus.in_rd;
            held_wen   <= bus.in_rf_wen;
            held_ecall <= (bus.in_csr_cmd == CMD_E);
         end else if (state == CSR_WAIT && wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
         end
         if (state_next == FLUSH && state != FLUSH)
            flush_cnt <= 4'(FLUSH_CYCLES - 1);
         else if (state == FLUSH && flush_cnt != 4'd0)
            flush_cnt <= flush_cnt - 4'd1;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (is_csr)
                  state_next = CSR_WAIT;
               else if (bus.in_br_taken)
                  state_next = FLUSH;
            end
         end
         CSR_WAIT: begin
            if (wait_done)
               state_next = held_ecall ? FLUSH : IDLE;
         end
         FLUSH: begin
            if (flush_done)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      case (bus.in_wb_sel)
         2'd0:    sel_data = bus.in_alu_out;
         2'd1:    sel_data = bus.in_mem_rdata;
         2'd2:    sel_data = bus.in_pc + 32'd4;
         default: sel_data = 32'd0;
      endcase
   end

   // Next values of the registered outputs; FLUSH leaves everything idle so
   // instructions accepted there vanish without side effects
   always_comb begin
      rf_wen_d      = 1'b0;
      rf_waddr_d    = rf_waddr_q;
      rf_wdata_d    = rf_wdata_q;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      retire_d      = 1'b0;
      if (state == IDLE && accept && !is_csr) begin
         retire_d   = 1'b1;
         rf_wen_d   = bus.in_rf_wen && (bus.in_rd != 5'd0);
         rf_waddr_d = bus.in_rd;
         rf_wdata_d = sel_data;
         if (bus.in_br_taken) begin
            redirect_d    = 1'b1;
            redirect_pc_d = bus.in_br_target;
         end
      end else if (wait_done) begin
         retire_d = 1'b1;
         if (held_ecall) begin
            redirect_d    = 1'b1;
            redirect_pc_d = bus.trap_vector;
         end else begin
            rf_wen_d   = held_wen && (held_rd != 5'd0);
            rf_waddr_d = held_rd;
            rf_wdata_d = bus.csr_rdata;
         end
      end
   end

   // Output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_wen_q      <= 1'b0;
         rf_waddr_q    <= 5'd0;
         rf_wdata_q    <= 32'd0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= 32'd0;
         hazard_q      <= 1'b0;
         retire_q      <= 64'd0;
      end else begin
         rf_wen_q      <= rf_wen_d;
         rf_waddr_q    <= rf_waddr_d;
         rf_wdata_q    <= rf_wdata_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         hazard_q      <= (state_next == FLUSH);
         retire_q      <= retire_q + 64'(retire_d);
      end
   end

   assign bus.rf_wen           = rf_wen_q;
   assign bus.rf_waddr         = rf_waddr_q;
   assign bus.rf_wdata         = rf_wdata_q;
   assign bus.redirect_valid   = redirect_q;
   assign bus.redirect_pc      = redirect_pc_q;
   assign bus.wb_branch_hazard = hazard_q;
   assign bus.retire_count     = retire_q;

endmodule

// File: tb/tb_csr_writeback_stage.sv
// Scoreboard bench for csr_writeback_stage: a cycle-indexed reference model predicts
// writes, redirects, squash windows, readiness and retire counts; a monitor compares.
module tb_csr_writeback_stage;

   localparam int LAT  = 1;
   localparam int FL   = 2;
   localparam int NCYC = 4096;

   typedef struct {
      int          cyc;
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        redir;
      logic [31:0] pc;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   logic mon_en = 1'b0;
   logic [63:0] exp_count = 64'd0;

   ev_t  sb[$];
   bit   notready [NCYC];
   bit   exp_hazard [NCYC];
   int   retire_inc [NCYC];

   csr_writeback_stage_if bus ();

   csr_writeback_stage #(.CSR_LATENCY(LAT), .FLUSH_CYCLES(FL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, wanted %0h", name, cyc, actual, expected);
      end
   endtask

   // One cycle of stimulus; the model decides from its own bookkeeping whether the
   // instruction is accepted, discarded in a squash window, or retired
   task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic [2:0] cmd,
                                 input logic [1:0] sel, input logic wen, input logic [4:0] rd,
                                 input logic [31:0] alu, input logic [31:0] mem, input logic tk,
                                 input logic [31:0] tgt, input logic [31:0] rdata, input logic [31:0] tvec);
      ev_t e;
      int  t;
      logic [31:0] wb;
      #1;
      bus.in_valid     = v;
      bus.in_pc        = pc;
      bus.in_csr_cmd   = cmd;
      bus.in_wb_sel    = sel;
      bus.in_rf_wen    = wen;
      bus.in_rd        = rd;
      bus.in_alu_out   = alu;
      bus.in_mem_rdata = mem;
      bus.in_br_taken  = tk;
      bus.in_br_target = tgt;
      if (v && !notready[cyc] && !exp_hazard[cyc]) begin
         if (cmd >= 3'd1 && cmd <= 3'd4) begin
            bus.csr_rdata   = rdata;
            bus.trap_vector = tvec;
            t = cyc + LAT + 1;
            for (int k = 1; k <= LAT; k++) notready[cyc + k] = 1'b1;
            retire_inc[t]++;
            if (cmd == 3'd4) begin
               e = '{cyc: t, wen: 1'b0, rd: 5'd0, data: 32'd0, redir: 1'b1, pc: tvec};
               sb.push_back(e);
               for (int k = 0; k < FL; k++) exp_hazard[t + k] = 1'b1;
            end else if (wen && rd != 5'd0) begin
               e = '{cyc: t, wen: 1'b1, rd: rd, data: rdata, redir: 1'b0, pc: 32'd0};
               sb.push_back(e);
            end
         end else begin
            t = cyc + 1;
            wb = (sel == 2'd0) ? alu : (sel == 2'd1) ? mem : (sel == 2'd2) ? pc + 32'd4 : 32'd0;
            retire_inc[t]++;
            if ((wen && rd != 5'd0) || tk) begin
               e = '{cyc: t, wen: wen && rd != 5'd0, rd: rd, data: wb, redir: tk, pc: tgt};
               sb.push_back(e);
            end
            if (tk)
               for (int k = 0; k < FL; k++) exp_hazard[t + k] = 1'b1;
         end
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic idle_cycle();
      apply_stimulus(1'b0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
   endtask

   task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
      apply_stimulus(1'b1, 32'h1000, 3'd0, 2'd0, 1'b1, rd, val, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
   endtask

   // Asynchronous reset in the middle of a cycle; model forgets everything pending
   task automatic do_reset();
      #2;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      sb.delete();
      exp_count = 64'd0;
      for (int k = cyc; k < NCYC; k++) begin
         notready[k]   = 1'b0;
         exp_hazard[k] = 1'b0;
         retire_inc[k] = 0;
      end
      #1;
      check_output("rst_hazard", {63'd0, bus.wb_branch_hazard}, 64'd0);
      check_output("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      check_output("rst_retire_count", bus.retire_count, 64'd0);
      check_output("rst_rf_wen", {63'd0, bus.rf_wen}, 64'd0);
      check_output("rst_redirect", {63'd0, bus.redirect_valid}, 64'd0);
      @(posedge clk);
      cyc++;
      #2;
      rst = 1'b0;
      @(posedge clk);
      cyc++;
   endtask

   // Monitor: per-cycle readiness, squash and count checks; pops the scoreboard on every output event
   always @(negedge clk) begin
      ev_t e;
      if (!rst && mon_en) begin
         exp_count = exp_count + 64'(retire_inc[cyc]);
         check_output("in_ready", {63'd0, bus.in_ready}, {63'd0, !notready[cyc]});
         check_output("hazard", {63'd0, bus.wb_branch_hazard}, {63'd0, exp_hazard[cyc]});
         check_output("retire_count", bus.retire_count, exp_count);
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            check_output("missing_event_cycle", 64'(cyc), 64'(sb[0].cyc));
            void'(sb.pop_front());
         end
         if (bus.rf_wen || bus.redirect_valid) begin
            if (sb.size() == 0) begin
               check_output("unexpected_event", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check_output("event_cycle", 64'(cyc), 64'(e.cyc));
               check_output("rf_wen", {63'd0, bus.rf_wen}, {63'd0, e.wen});
               check_output("redirect_valid", {63'd0, bus.redirect_valid}, {63'd0, e.redir});
               if (e.wen) begin
                  check_output("rf_waddr", {59'd0, bus.rf_waddr}, {59'd0, e.rd});
                  check_output("rf_wdata", {32'd0, bus.rf_wdata}, {32'd0, e.data});
               end
               if (e.redir)
                  check_output("redirect_pc", {32'd0, bus.redirect_pc}, {32'd0, e.pc});
            end
         end
      end
   end

   initial begin
      logic [2:0] cmd;
      int r;
      bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_csr_cmd = '0; bus.in_wb_sel = '0;
      bus.in_rf_wen = 1'b0; bus.in_rd = '0; bus.in_alu_out = '0; bus.in_mem_rdata = '0;
      bus.in_br_taken = 1'b0; bus.in_br_target = '0; bus.csr_rdata = '0; bus.trap_vector = '0;
      for (int k = 0; k < NCYC; k++) begin
         notready[k] = 1'b0; exp_hazard[k] = 1'b0; retire_inc[k] = 0;
      end
      @(posedge clk);
      cyc++;
      do_reset();
      mon_en = 1'b1;

      // ALU write, then rd=0 which retires without writing
      alu_op(5'd5, 32'h1234);
      alu_op(5'd0, 32'h5555);
      // CSRRW x7 and ECALL to 0x100
      apply_stimulus(1'b1, 32'h2000, 3'd1, 2'd3, 1'b1, 5'd7, 32'd0, 32'd0, 1'b0, 32'd0, 32'hDEADBEEF, 32'd0);
      idle_cycle();
      apply_stimulus(1'b1, 32'h2004, 3'd4, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'h100);
      repeat (4) idle_cycle();
      // JAL x1 to 0x80, followed by two CSRRW ops inside the squash window
      apply_stimulus(1'b1, 32'h40, 3'd0, 2'd2, 1'b1, 5'd1, 32'd0, 32'd0, 1'b1, 32'h80, 32'd0, 32'd0);
      apply_stimulus(1'b1, 32'h44, 3'd1, 2'd3, 1'b1, 5'd9, 32'd0, 32'd0, 1'b0, 32'd0, 32'h11111111, 32'd0);
      apply_stimulus(1'b1, 32'h48, 3'd1, 2'd3, 1'b1, 5'd10, 32'd0, 32'd0, 1'b0, 32'd0, 32'h22222222, 32'd0);
      repeat (2) idle_cycle();

      // Ten back-to-back ALU ops from a clean count
      do_reset();
      for (int i = 0; i < 10; i++) alu_op(5'(i + 1), 32'(i * 7 + 3));
      repeat (2) idle_cycle();
      check_output("ten_retired", bus.retire_count, 64'd10);

      // Reset in the middle of a squash window, then a normal ALU op
      apply_stimulus(1'b1, 32'h300, 3'd0, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 32'h400, 32'd0, 32'd0);
      idle_cycle();
      do_reset();
      alu_op(5'd3, 32'hCAFE);
      repeat (2) idle_cycle();

      // Randomised traffic
      for (int i = 0; i < 500; i++) begin
         r = int'($urandom_range(0, 9));
         cmd = (r <= 5) ? 3'd0 : 3'(r - 5);
         apply_stimulus($urandom_range(0, 9) < 7, $urandom, cmd, 2'($urandom_range(0, 3)),
                        1'($urandom), 5'($urandom), $urandom, $urandom,
                        $urandom_range(0, 4) == 0, $urandom, $urandom, $urandom);
      end
      repeat (8) idle_cycle();
      check_output("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
